// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity_err.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 12000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q, sync_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_busy_q, rx_busy_d;
  logic               frame_err_q, frame_err_d;
  logic               rx_s;
  logic               bit_end;
  logic               half_end;
`ifdef UART_RX_PARITY_EN
  logic               par_bit_q, par_bit_d;
  logic               parity_err_q, parity_err_d;
`endif

  assign rx_s     = sync_q[1];
  assign bit_end  = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign half_end = (clk_cnt_q == CNT_W'(HALF_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_busy_q   <= rx_busy_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rx};
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        // Re-check the line at mid start bit to reject short glitches
        if (half_end) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          par_bit_d = rx_s;
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        // Leave at the stop-bit midpoint to keep half a bit of slack
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bit_q != ^shift_q) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_busy_d = (state_d != S_IDLE);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboard of expected bytes, strobe counters.
// Define UART_RX_PARITY_EN to also exercise the 8E1 parity path.
module tb_uart_rx;

  localparam int unsigned BIT   = 104;
  localparam int unsigned FRAME = 10 * BIT;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  logic       busy_seen = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_perr = 1'b0;
  logic [7:0] exp_q[$];
  int         vt[$];

  uart_rx #(.CLK_FREQ(12000000), .BAUD(115200)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and strobe monitor
  always @(negedge clk) begin
    if (rx_busy) busy_seen = 1'b1;
    if (rx_valid || frame_err || parity_err)
      check("strobe_exclusive", 32'($countones({rx_valid, frame_err, parity_err})), 32'd1);
    if (rx_valid) begin
      valid_cnt++;
      vt.push_back(cyc);
      check("valid_one_cycle", 32'(prev_valid), 32'd0);
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rx_data_sb", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    if (frame_err) begin
      ferr_cnt++;
      check("ferr_one_cycle", 32'(prev_ferr), 32'd0);
    end
    if (parity_err) begin
      perr_cnt++;
      check("perr_one_cycle", 32'(prev_perr), 32'd0);
    end
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
    prev_perr  = parity_err;
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par) begin end
`endif
    drive_bit(stop);
    rx = 1'b1;
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  initial begin
    int v0;
    int f0;
    logic [7:0] hi [3];
    hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_busy", 32'(rx_busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    repeat (20) @(negedge clk);

    // Single byte 0x55; busy must be gone by the end of the stop bit
    exp_q.push_back(8'h55);
    send(8'h55, even_par(8'h55), 1'b1);
    check("b55_valid_cnt", 32'(valid_cnt), 32'd1);
    check("b55_rx_data", 32'(rx_data), 32'h55);
    check("b55_busy_low", 32'(rx_busy), 32'd0);
    repeat (50) @(negedge clk);

    // Back-to-back "Hi\n"
    v0 = valid_cnt;
    f0 = ferr_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(hi[i]);
      send(hi[i], even_par(hi[i]), 1'b1);
    end
    repeat (20) @(negedge clk);
    check("hi_valid_cnt", 32'(valid_cnt - v0), 32'd3);
    check("hi_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("hi_rx_data", 32'(rx_data), 32'h0A);
    check("hi_vt_size", 32'(vt.size()), 32'd4);
    if (vt.size() == 4) begin
      check("hi_gap1", 32'(vt[2] - vt[1]), 32'(FRAME));
      check("hi_gap2", 32'(vt[3] - vt[2]), 32'(FRAME));
    end

    // Start-bit glitch
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_busy_low", 32'(rx_busy), 32'd0);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_rx_data", 32'(rx_data), 32'h0A);

    // 0xA3 with a bad stop bit
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send(8'hA3, even_par(8'hA3), 1'b0);
    repeat (300) @(negedge clk);
    check("ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("ferr_rx_data", 32'(rx_data), 32'h0A);
    check("ferr_busy_low", 32'(rx_busy), 32'd0);

    // Reset during data bit 4, then a clean 0x0F
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b0;
    repeat (52) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    check("mrst_rx_data", 32'(rx_data), 32'h00);
    check("mrst_rx_valid", 32'(rx_valid), 32'd0);
    check("mrst_rx_busy", 32'(rx_busy), 32'd0);
    check("mrst_frame_err", 32'(frame_err), 32'd0);
    check("mrst_parity_err", 32'(parity_err), 32'd0);
    repeat (5 * BIT) @(negedge clk);
    check("mrst_idle_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("mrst_idle_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    exp_q.push_back(8'h0F);
    send(8'h0F, even_par(8'h0F), 1'b1);
    check("mrst_0f_valid", 32'(valid_cnt - v0), 32'd1);
    check("mrst_0f_rx_data", 32'(rx_data), 32'h0F);
    repeat (50) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // Wrong then correct parity on 0x07
    v0 = valid_cnt;
    send(8'h07, 1'b0, 1'b1);
    repeat (50) @(negedge clk);
    check("par_bad_perr", 32'(perr_cnt), 32'd1);
    check("par_bad_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("par_bad_rx_data", 32'(rx_data), 32'h0F);
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    check("par_good_valid", 32'(valid_cnt - v0), 32'd1);
    check("par_good_rx_data", 32'(rx_data), 32'h07);
    check("par_good_perr", 32'(perr_cnt), 32'd1);
`else
    check("no_parity_err", 32'(perr_cnt), 32'd0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
